// File: rtl/uart_receiver_param_if.sv
// Consumer-side bus of the UART receiver: FIFO head data, error flags and pop strobe.
// Rx_NERROR is only present when UART_RX_NOISE_DETECT_EN is defined.
interface uart_receiver_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 Rx_READ;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_PERROR;
    logic                 Rx_FERROR;
    logic                 Rx_OVERRUN;
`ifdef UART_RX_NOISE_DETECT_EN
    logic                 Rx_NERROR;
`endif

    modport master (
        input  Rx_READ,
        output Rx_DATA,
        output Rx_VALID,
        output Rx_PERROR,
        output Rx_FERROR,
`ifdef UART_RX_NOISE_DETECT_EN
        output Rx_NERROR,
`endif
        output Rx_OVERRUN
    );

    modport slave (
        output Rx_READ,
        input  Rx_DATA,
        input  Rx_VALID,
        input  Rx_PERROR,
        input  Rx_FERROR,
`ifdef UART_RX_NOISE_DETECT_EN
        input  Rx_NERROR,
`endif
        input  Rx_OVERRUN
    );
endinterface

// File: rtl/uart_receiver_param.sv
// Oversampling UART receiver with majority-vote bits, runtime parity/stop config and receive FIFO.
// Optional macro UART_RX_NOISE_DETECT_EN adds a per-word noise flag (Rx_NERROR).
module uart_receiver_param #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            baud_select,
    input  logic                  RX_EN,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic                  RxD,
    uart_receiver_param_if.master rx_if
);
    function automatic int unsigned calc_div(input int unsigned baud);
        int unsigned q;
        q = (CLK_HZ + (OVERSAMPLE * baud) / 32'd2) / (OVERSAMPLE * baud);
        return (q == 32'd0) ? 32'd1 : q;
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    localparam int unsigned DIV0 = calc_div(32'd300);
    localparam int unsigned DIV1 = calc_div(32'd1200);
    localparam int unsigned DIV2 = calc_div(32'd4800);
    localparam int unsigned DIV3 = calc_div(32'd9600);
    localparam int unsigned DIV4 = calc_div(32'd19200);
    localparam int unsigned DIV5 = calc_div(32'd38400);
    localparam int unsigned DIV6 = calc_div(32'd57600);
    localparam int unsigned DIV7 = calc_div(32'd115200);
    localparam int unsigned DIVW = $clog2(DIV0 + 32'd1);
    localparam int unsigned SW   = $clog2(OVERSAMPLE);
    localparam int unsigned BCW  = $clog2(DATA_BITS + 32'd1);
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
`ifdef UART_RX_NOISE_DETECT_EN
    localparam int unsigned EW   = DATA_BITS + 32'd3;
`else
    localparam int unsigned EW   = DATA_BITS + 32'd2;
`endif
    localparam logic [SW-1:0]  SMP_A    = SW'(OVERSAMPLE / 32'd2 - 32'd1);
    localparam logic [SW-1:0]  SMP_MID  = SW'(OVERSAMPLE / 32'd2);
    localparam logic [SW-1:0]  SMP_B    = SW'(OVERSAMPLE / 32'd2 + 32'd1);
    localparam logic [SW-1:0]  SMP_LAST = SW'(OVERSAMPLE - 32'd1);
    localparam logic [BCW-1:0] BITS_ALL = BCW'(DATA_BITS);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, PUSH} state_t;

    state_t               state_q, state_d;
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [2:0]           baud_q, baud_d;
    logic [1:0]           par_q, par_d;
    logic                 two_q, two_d;
    logic [DIVW-1:0]      div_cnt_q, div_cnt_d, div_max_s;
    logic [SW-1:0]        smp_cnt_q, smp_cnt_d;
    logic [2:0]           samp_q, samp_d;
    logic                 vote_rdy_q, vote_rdy_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 tick_s, end_bit_s, fall_s, vote_s, active_s;
`ifdef UART_RX_NOISE_DETECT_EN
    logic                 nerr_q, nerr_d, noisy_s;
`endif

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [EW-1:0]        head_q, head_d, wdata_s;
    logic                 valid_q, valid_d, ovr_q, ovr_d;
    logic                 push_s, pop_s, full_s, wr_en_s, drop_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign fall_s    = rxd_prev_q & ~rxd_sync_q;
    assign tick_s    = (div_cnt_q == div_max_s);
    assign end_bit_s = tick_s && (smp_cnt_q == SMP_LAST);
    assign active_s  = (state_q != IDLE) && (state_q != PUSH);
    assign vote_s    = maj3(samp_q);
`ifdef UART_RX_NOISE_DETECT_EN
    assign noisy_s   = (samp_q != 3'b000) && (samp_q != 3'b111);
`endif

    // Oversample tick divisor for the baud rate latched at start detection.
    always_comb begin
        div_max_s = DIVW'(DIV0 - 32'd1);
        case (baud_q)
            3'd0:    div_max_s = DIVW'(DIV0 - 32'd1);
            3'd1:    div_max_s = DIVW'(DIV1 - 32'd1);
            3'd2:    div_max_s = DIVW'(DIV2 - 32'd1);
            3'd3:    div_max_s = DIVW'(DIV3 - 32'd1);
            3'd4:    div_max_s = DIVW'(DIV4 - 32'd1);
            3'd5:    div_max_s = DIVW'(DIV5 - 32'd1);
            3'd6:    div_max_s = DIVW'(DIV6 - 32'd1);
            3'd7:    div_max_s = DIVW'(DIV7 - 32'd1);
            default: div_max_s = DIVW'(DIV0 - 32'd1);
        endcase
    end

    // Frame FSM: next state and bit-level datapath.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        par_d      = par_q;
        two_d      = two_q;
        div_cnt_d  = tick_s ? '0 : div_cnt_q + 1'b1;
        smp_cnt_d  = smp_cnt_q;
        samp_d     = samp_q;
        vote_rdy_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
`ifdef UART_RX_NOISE_DETECT_EN
        nerr_d     = (vote_rdy_q && active_s) ? (nerr_q | noisy_s) : nerr_q;
`endif
        // Three samples around mid-bit; the vote is acted on one cycle after the last one.
        if (active_s && tick_s) begin
            smp_cnt_d  = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
            samp_d     = ((smp_cnt_q == SMP_A) || (smp_cnt_q == SMP_MID) || (smp_cnt_q == SMP_B))
                         ? {samp_q[1:0], rxd_sync_q} : samp_q;
            vote_rdy_d = (smp_cnt_q == SMP_B);
        end else begin
            vote_rdy_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (RX_EN && fall_s) begin
                    state_d   = START;
                    baud_d    = baud_select;
                    par_d     = parity_mode;
                    two_d     = two_stop;
                    div_cnt_d = '0;
                    smp_cnt_d = '0;
                    samp_d    = 3'b111;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
`ifdef UART_RX_NOISE_DETECT_EN
                    nerr_d    = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s && (smp_cnt_q == SMP_MID) && rxd_sync_q) begin
                    state_d = IDLE;
                end else if (end_bit_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (vote_rdy_q) begin
                    shift_d   = {vote_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    shift_d = shift_q;
                end
                if (end_bit_s && (bit_cnt_q == BITS_ALL)) begin
                    state_d = (par_q != 2'b00) ? PARITY : STOP1;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                // Odd mode inverts the even-parity check; reserved mode 11 behaves as even.
                if (vote_rdy_q) begin
                    perr_d = (^shift_q) ^ vote_s ^ (par_q == 2'b10);
                end else begin
                    perr_d = perr_q;
                end
                state_d = end_bit_s ? STOP1 : PARITY;
            end
            STOP1: begin
                if (vote_rdy_q) begin
                    ferr_d  = ferr_q | ~vote_s;
                    state_d = two_q ? STOP1 : PUSH;
                end else if (end_bit_s && two_q) begin
                    state_d = STOP2;
                end else begin
                    state_d = STOP1;
                end
            end
            STOP2: begin
                if (vote_rdy_q) begin
                    ferr_d  = ferr_q | ~vote_s;
                    state_d = PUSH;
                end else begin
                    state_d = STOP2;
                end
            end
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!RX_EN && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Frame FSM and bit datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= 3'd0;
            par_q      <= 2'b00;
            two_q      <= 1'b0;
            div_cnt_q  <= '0;
            smp_cnt_q  <= '0;
            samp_q     <= 3'b111;
            vote_rdy_q <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_NOISE_DETECT_EN
            nerr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            par_q      <= par_d;
            two_q      <= two_d;
            div_cnt_q  <= div_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            samp_q     <= samp_d;
            vote_rdy_q <= vote_rdy_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_NOISE_DETECT_EN
            nerr_q     <= nerr_d;
`endif
        end
    end

`ifdef UART_RX_NOISE_DETECT_EN
    assign wdata_s = {nerr_q, perr_q, ferr_q, shift_q};
`else
    assign wdata_s = {perr_q, ferr_q, shift_q};
`endif
    assign push_s  = (state_q == PUSH);
    assign pop_s   = rx_if.Rx_READ && valid_q;
    assign full_s  = (count_q == CNT_FULL);
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // FIFO bookkeeping; the head register is loaded from next-state pointers so it never lags a pop.
    always_comb begin
        wr_ptr_d = wr_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovr_d   = pop_s ? 1'b0 : (drop_s ? 1'b1 : ovr_q);
        valid_d = (count_d != '0);
        if (count_d == '0) begin
            head_d = '0;
        end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = wdata_s;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage, pointers and registered head outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= wdata_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_if.Rx_DATA    = head_q[DATA_BITS-1:0];
    assign rx_if.Rx_FERROR  = head_q[DATA_BITS];
    assign rx_if.Rx_PERROR  = head_q[DATA_BITS+1];
`ifdef UART_RX_NOISE_DETECT_EN
    assign rx_if.Rx_NERROR  = head_q[DATA_BITS+2];
`endif
    assign rx_if.Rx_VALID   = valid_q;
    assign rx_if.Rx_OVERRUN = ovr_q;
endmodule

// File: tb/tb_uart_receiver_param.sv
// Scoreboard bench for uart_receiver_param at 115200 baud with a reduced clock (divisor 4, 64 clk/bit).
module tb_uart_receiver_param;
    localparam int unsigned CLK_HZ   = 7372800;
    localparam int unsigned BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       n;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_select;
    logic       RX_EN;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       RxD;
    int         errors = 0;
    int         checks = 0;
    int         pop_count = 0;
    bit         auto_read = 1'b0;
    exp_t       exp_q[$];

    uart_receiver_param_if #(.DATA_BITS(8)) rx_if ();

    uart_receiver_param #(
        .CLK_HZ(CLK_HZ), .OVERSAMPLE(16), .DATA_BITS(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .baud_select(baud_select), .RX_EN(RX_EN),
        .parity_mode(parity_mode), .two_stop(two_stop), .RxD(RxD), .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic hold_bit(input logic b, input int clks);
        RxD = b;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int bits);
        hold_bit(1'b1, bits * BIT_CLKS);
    endtask

    task automatic expect_word(input logic [7:0] d, input logic p, input logic f, input logic n);
        exp_t e;
        e.d = d; e.p = p; e.f = f; e.n = n;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic s1, input logic has_s2, input logic s2);
        hold_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold_bit(d[i], BIT_CLKS);
        if (has_par) hold_bit(par_bit, BIT_CLKS);
        hold_bit(s1, BIT_CLKS);
        if (has_s2) hold_bit(s2, BIT_CLKS);
        RxD = 1'b1;
    endtask

    task automatic wait_pops(input int target, input string name);
        for (int k = 0; k < 20 * BIT_CLKS && pop_count < target; k++) @(negedge clk);
        check(name, 16'(pop_count >= target), 16'd1);
    endtask

    // Consumer: pops whenever a word is presented and compares it against the scoreboard.
    initial begin
        exp_t e;
        rx_if.Rx_READ = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_read && rx_if.Rx_VALID && !reset) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_word unexpected data=%h", rx_if.Rx_DATA);
                end else begin
                    e = exp_q.pop_front();
`ifdef UART_RX_NOISE_DETECT_EN
                    if ({rx_if.Rx_DATA, rx_if.Rx_PERROR, rx_if.Rx_FERROR, rx_if.Rx_NERROR} !== e) begin
`else
                    if ({rx_if.Rx_DATA, rx_if.Rx_PERROR, rx_if.Rx_FERROR} !== {e.d, e.p, e.f}) begin
`endif
                        errors++;
                        $display("FAIL rx_word actual data=%h p=%b f=%b required data=%h p=%b f=%b n=%b",
                                 rx_if.Rx_DATA, rx_if.Rx_PERROR, rx_if.Rx_FERROR, e.d, e.p, e.f, e.n);
                    end
                end
                rx_if.Rx_READ = 1'b1;
                pop_count++;
            end else begin
                rx_if.Rx_READ = 1'b0;
            end
        end
    end

    initial begin
        int base;
        RxD = 1'b1; RX_EN = 1'b1; baud_select = 3'd7; parity_mode = 2'b01; two_stop = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_valid", 16'(rx_if.Rx_VALID), 16'd0);
        check("reset_data", 16'(rx_if.Rx_DATA), 16'd0);
        check("reset_overrun", 16'(rx_if.Rx_OVERRUN), 16'd0);
        reset = 1'b0;
        idle(2);
        auto_read = 1'b1;

        expect_word(8'h85, 1'b0, 1'b0, 1'b0); send_frame(8'h85, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); idle(3);
        expect_word(8'h85, 1'b1, 1'b0, 1'b0); send_frame(8'h85, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); idle(3);
        parity_mode = 2'b10;
        expect_word(8'h85, 1'b0, 1'b0, 1'b0); send_frame(8'h85, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); idle(3);
        parity_mode = 2'b01;
        expect_word(8'h85, 1'b0, 1'b1, 1'b0); send_frame(8'h85, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); idle(3);
        two_stop = 1'b1;
        expect_word(8'h85, 1'b0, 1'b1, 1'b0); send_frame(8'h85, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); idle(3);
        two_stop = 1'b0;
        wait_pops(5, "basic_pops");

        base = pop_count;
        hold_bit(1'b0, BIT_CLKS / 4);
        idle(3);
        check("false_start_valid", 16'(rx_if.Rx_VALID), 16'd0);
        check("false_start_pops", 16'(pop_count), 16'(base));

        auto_read = 1'b0;
        parity_mode = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_word(8'(i), 1'b0, 1'b0, 1'b0);
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle(2);
        check("overrun_set", 16'(rx_if.Rx_OVERRUN), 16'd1);
        check("overrun_head", 16'(rx_if.Rx_DATA), 16'h01);
        base = pop_count;
        auto_read = 1'b1;
        wait_pops(base + 1, "overrun_first_pop");
        @(negedge clk);
        @(negedge clk);
        check("overrun_cleared", 16'(rx_if.Rx_OVERRUN), 16'd0);
        wait_pops(base + 4, "overrun_drain");
        idle(1);
        check("overrun_empty", 16'(rx_if.Rx_VALID), 16'd0);

        auto_read = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("pre_reset_data", 16'(rx_if.Rx_DATA), 16'h5A);
        hold_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 3; i++) hold_bit(1'b1, BIT_CLKS);
        hold_bit(1'b0, BIT_CLKS / 2);
        reset = 1'b1;
        #1;
        check("reset_mid_valid", 16'(rx_if.Rx_VALID), 16'd0);
        check("reset_mid_data", 16'(rx_if.Rx_DATA), 16'd0);
        RxD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(12);
        check("post_reset_valid", 16'(rx_if.Rx_VALID), 16'd0);

        expect_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        hold_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 5; i++) hold_bit(1'b0, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS / 2);
        RX_EN = 1'b0;
        hold_bit(1'b0, 4);
        idle(12);
        RX_EN = 1'b1;
        idle(1);
        check("abort_kept_valid", 16'(rx_if.Rx_VALID), 16'd1);
        check("abort_kept_data", 16'(rx_if.Rx_DATA), 16'h11);
        expect_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        base = pop_count;
        auto_read = 1'b1;
        wait_pops(base + 2, "abort_drain");
        idle(1);
        check("abort_empty", 16'(rx_if.Rx_VALID), 16'd0);

`ifdef UART_RX_NOISE_DETECT_EN
        parity_mode = 2'b01;
        expect_word(8'h85, 1'b0, 1'b0, 1'b1);
        hold_bit(1'b0, BIT_CLKS);
        hold_bit(1'b1, 34);
        hold_bit(1'b0, 6);
        hold_bit(1'b1, 24);
        for (int i = 1; i < 8; i++) hold_bit(i == 7, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS);
        hold_bit(1'b1, BIT_CLKS);
        base = pop_count;
        wait_pops(base + 1, "noise_pop");
        idle(1);
`endif

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
